// File: rtl/control_pipeline_if.sv
// rtl/control_pipeline_if.sv - decode-side inputs and per-stage control outputs of the control pipeline
interface control_pipeline_if;
  // Decode-stage control and register indices
  logic       id_RegWrite;
  logic       id_ALUSrc;
  logic       id_MemWrite;
  logic       id_ResultSrc;
  logic       id_Branch;
  logic [1:0] id_ALUOp;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;

  // ALU zero flag for the instruction currently in EX
  logic       ex_Zero;

  // EX-stage control
  logic       ex_ALUSrc;
  logic [1:0] ex_ALUOp;
  logic [4:0] ex_rd;

  // MEM-stage control
  logic       mem_MemWrite;
  logic       mem_RegWrite;
  logic [4:0] mem_rd;

  // WB-stage control
  logic       wb_RegWrite;
  logic       wb_ResultSrc;
  logic [4:0] wb_rd;

  // Hazard and redirect controls
  logic       stall_F;
  logic       stall_D;
  logic       flush_D;
  logic       PCSrc_E;

  modport master (
    output id_RegWrite, id_ALUSrc, id_MemWrite, id_ResultSrc, id_Branch,
    output id_ALUOp, id_rs1, id_rs2, id_rd, ex_Zero,
    input  ex_ALUSrc, ex_ALUOp, ex_rd,
    input  mem_MemWrite, mem_RegWrite, mem_rd,
    input  wb_RegWrite, wb_ResultSrc, wb_rd,
    input  stall_F, stall_D, flush_D, PCSrc_E
  );

  modport slave (
    input  id_RegWrite, id_ALUSrc, id_MemWrite, id_ResultSrc, id_Branch,
    input  id_ALUOp, id_rs1, id_rs2, id_rd, ex_Zero,
    output ex_ALUSrc, ex_ALUOp, ex_rd,
    output mem_MemWrite, mem_RegWrite, mem_rd,
    output wb_RegWrite, wb_ResultSrc, wb_rd,
    output stall_F, stall_D, flush_D, PCSrc_E
  );
endinterface

// File: rtl/control_pipeline.sv
// rtl/control_pipeline.sv - ID/EX, EX/MEM, MEM/WB control registers with load-use stall and branch flush
module control_pipeline (
  input  logic               clk,
  input  logic               rst_n,
  control_pipeline_if.slave  bus
);

  // Control word carried by every stage register
  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       result_src;
    logic       branch;
    logic [1:0] alu_op;
    logic [4:0] rd;
  } stage_t;

  localparam stage_t BUBBLE = '0;

  stage_t id_ex_d,  id_ex_q;
  stage_t ex_mem_d, ex_mem_q;
  stage_t mem_wb_d, mem_wb_q;

  logic pc_src_e;
  logic load_use;
  logic ex_rd_nonzero;
  logic ex_rd_matches;

  // Redirect: the branch in EX is taken when the ALU reports equality.
  assign pc_src_e = id_ex_q.branch & bus.ex_Zero;

  // Load-use: a load in EX writes a register the instruction in ID reads.
  // Only ID/EX state and the decode source indices feed this path.
  assign ex_rd_nonzero = (id_ex_q.rd != 5'd0);
  assign ex_rd_matches = (id_ex_q.rd == bus.id_rs1) | (id_ex_q.rd == bus.id_rs2);
  assign load_use      = id_ex_q.result_src & id_ex_q.reg_write & ex_rd_nonzero & ex_rd_matches;

  // A taken branch wins over load-use: the dependent instruction is being
  // flushed anyway, so stalling for it would only cost a cycle.
  assign bus.PCSrc_E = pc_src_e;
  assign bus.flush_D = pc_src_e;
  assign bus.stall_F = load_use & ~pc_src_e;
  assign bus.stall_D = load_use & ~pc_src_e;

  // ID/EX next value: decode controls, or a bubble on flush or load-use stall
  always_comb begin
    id_ex_d            = BUBBLE;
    id_ex_d.reg_write  = bus.id_RegWrite & (bus.id_rd != 5'd0);
    id_ex_d.alu_src    = bus.id_ALUSrc;
    id_ex_d.mem_write  = bus.id_MemWrite;
    id_ex_d.result_src = bus.id_ResultSrc;
    id_ex_d.branch     = bus.id_Branch;
    id_ex_d.alu_op     = bus.id_ALUOp;
    id_ex_d.rd         = bus.id_rd;
    if (pc_src_e || load_use) begin
      id_ex_d = BUBBLE;
    end
  end

  // EX/MEM and MEM/WB next values: nothing stalls downstream of EX
  always_comb begin
    ex_mem_d = id_ex_q;
    mem_wb_d = ex_mem_q;
  end

  // Stage registers; reset discards every in-flight instruction at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q  <= BUBBLE;
      ex_mem_q <= BUBBLE;
      mem_wb_q <= BUBBLE;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  // Stage outputs
  assign bus.ex_ALUSrc    = id_ex_q.alu_src;
  assign bus.ex_ALUOp     = id_ex_q.alu_op;
  assign bus.ex_rd        = id_ex_q.rd;

  assign bus.mem_MemWrite = ex_mem_q.mem_write;
  assign bus.mem_RegWrite = ex_mem_q.reg_write;
  assign bus.mem_rd       = ex_mem_q.rd;

  assign bus.wb_RegWrite  = mem_wb_q.reg_write;
  assign bus.wb_ResultSrc = mem_wb_q.result_src;
  assign bus.wb_rd        = mem_wb_q.rd;

  // MEM/WB carries the full control word for uniformity; the fields that
  // have no consumer in WB are gathered here.
  logic unused_mem_wb;
  assign unused_mem_wb = ^{mem_wb_q.alu_src, mem_wb_q.mem_write,
                           mem_wb_q.branch, mem_wb_q.alu_op};

endmodule

// File: tb/tb_control_pipeline.sv
// tb/tb_control_pipeline.sv - scoreboard bench for control_pipeline
module tb_control_pipeline;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  control_pipeline_if bus ();

  control_pipeline dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       rw;
    logic       alusrc;
    logic       memw;
    logic       rsrc;
    logic       br;
    logic [1:0] aluop;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       zero;
  } instr_t;

  typedef struct packed {
    logic       rw;
    logic       alusrc;
    logic       memw;
    logic       rsrc;
    logic       br;
    logic [1:0] aluop;
    logic [4:0] rd;
  } ent_t;

  // Entries in the order they entered ID/EX; the newest is in EX
  ent_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t mk(input logic rw, input logic alusrc, input logic memw,
                                input logic rsrc, input logic br, input logic [1:0] aluop,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic zero);
    instr_t i;
    i.rw = rw; i.alusrc = alusrc; i.memw = memw; i.rsrc = rsrc; i.br = br;
    i.aluop = aluop; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.zero = zero;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    bus.id_RegWrite  = i.rw;
    bus.id_ALUSrc    = i.alusrc;
    bus.id_MemWrite  = i.memw;
    bus.id_ResultSrc = i.rsrc;
    bus.id_Branch    = i.br;
    bus.id_ALUOp     = i.aluop;
    bus.id_rs1       = i.rs1;
    bus.id_rs2       = i.rs2;
    bus.id_rd        = i.rd;
    bus.ex_Zero      = i.zero;
  endtask

  task automatic sb_reset();
    sb.delete();
    repeat (3) sb.push_back('0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {6'd0, bus.ex_ALUSrc, bus.ex_ALUOp, bus.ex_rd,
                   bus.mem_MemWrite, bus.mem_RegWrite, bus.mem_rd,
                   bus.wb_RegWrite, bus.wb_ResultSrc, bus.wb_rd,
                   bus.stall_F, bus.stall_D, bus.flush_D, bus.PCSrc_E}, 32'd0);
  endtask

  // Compare registered stage outputs against the scoreboard, retire WB entry
  task automatic check_regs();
    ent_t ex, mem, wb;
    ex  = sb[sb.size()-1];
    mem = sb[sb.size()-2];
    wb  = sb[sb.size()-3];
    check_eq("ex_ALUSrc",    bus.ex_ALUSrc,    ex.alusrc);
    check_eq("ex_ALUOp",     bus.ex_ALUOp,     ex.aluop);
    check_eq("ex_rd",        bus.ex_rd,        ex.rd);
    check_eq("mem_MemWrite", bus.mem_MemWrite, mem.memw);
    check_eq("mem_RegWrite", bus.mem_RegWrite, mem.rw);
    check_eq("mem_rd",       bus.mem_rd,       mem.rd);
    check_eq("wb_RegWrite",  bus.wb_RegWrite,  wb.rw);
    check_eq("wb_ResultSrc", bus.wb_ResultSrc, wb.rsrc);
    check_eq("wb_rd",        bus.wb_rd,        wb.rd);
    while (sb.size() > 3) void'(sb.pop_front());
  endtask

  // One cycle: check registers, present an instruction, check hazards, push
  task automatic step(input instr_t i, output logic exp_stall, output logic obs_stall);
    ent_t ex, e;
    logic pc, lu;
    @(negedge clk);
    check_regs();
    drive(i);
    #1;
    ex = sb[sb.size()-1];
    pc = ex.br & i.zero;
    lu = ex.rsrc & ex.rw & (ex.rd != 5'd0) & ((ex.rd == i.rs1) | (ex.rd == i.rs2));
    check_eq("PCSrc_E", bus.PCSrc_E, pc);
    check_eq("flush_D", bus.flush_D, pc);
    check_eq("stall_F", bus.stall_F, lu & ~pc);
    check_eq("stall_D", bus.stall_D, lu & ~pc);
    if (pc || lu) begin
      e = '0;
    end else begin
      e.rw = i.rw & (i.rd != 5'd0);
      e.alusrc = i.alusrc; e.memw = i.memw; e.rsrc = i.rsrc;
      e.br = i.br; e.aluop = i.aluop; e.rd = i.rd;
    end
    sb.push_back(e);
    exp_stall = lu & ~pc;
    obs_stall = bus.stall_F;
  endtask

  // Issue an instruction, re-presenting it while decode is stalled
  task automatic issue(input instr_t i, output int stalls);
    logic es, os;
    stalls = 0;
    for (int a = 0; a < 3; a++) begin
      step(i, es, os);
      if (os) stalls++;
      if (!es) break;
    end
  endtask

  instr_t nop, rtype, lw7, use7, lw0, use0, beq, nxt, weird, use3, sw, r9, r;
  int st;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    nop   = '0;
    rtype = mk(1, 0, 0, 0, 0, 2'b10, 5'd1, 5'd2, 5'd5, 0);
    lw7   = mk(1, 1, 0, 1, 0, 2'b00, 5'd2, 5'd0, 5'd7, 0);
    use7  = mk(1, 0, 0, 0, 0, 2'b10, 5'd7, 5'd4, 5'd8, 0);
    lw0   = mk(1, 1, 0, 1, 0, 2'b00, 5'd2, 5'd0, 5'd0, 0);
    use0  = mk(1, 0, 0, 0, 0, 2'b10, 5'd0, 5'd4, 5'd9, 0);
    beq   = mk(0, 0, 0, 0, 1, 2'b01, 5'd1, 5'd2, 5'd0, 0);
    nxt   = mk(1, 1, 0, 0, 0, 2'b10, 5'd3, 5'd4, 5'd6, 1);
    weird = mk(1, 0, 0, 1, 1, 2'b01, 5'd1, 5'd2, 5'd3, 0);
    use3  = mk(1, 0, 0, 0, 0, 2'b10, 5'd3, 5'd5, 5'd10, 1);
    sw    = mk(0, 1, 1, 0, 0, 2'b00, 5'd1, 5'd2, 5'd0, 0);
    r9    = mk(1, 0, 0, 0, 0, 2'b11, 5'd1, 5'd2, 5'd9, 0);

    // Reset state
    drive(nop);
    @(posedge clk); #1;
    check_all_zero("reset_outputs");
    @(posedge clk); #2;
    rst_n = 1'b1;
    sb_reset();

    // R-type through all stages, then bubbles
    issue(rtype, st);
    repeat (4) issue(nop, st);

    // Load-use on rs1: exactly one stall cycle
    issue(lw7, st);
    issue(use7, st);
    check_eq("lu_stall_cycles", st, 1);
    repeat (3) issue(nop, st);

    // Load to x0: no stall, RegWrite never set
    issue(lw0, st);
    issue(use0, st);
    check_eq("x0_stall_cycles", st, 0);
    repeat (3) issue(nop, st);

    // Branch taken, then not taken
    issue(beq, st);
    issue(nxt, st);
    issue(beq, st);
    nxt.zero = 1'b0;
    issue(nxt, st);
    repeat (3) issue(nop, st);

    // Branch and load-use together: branch wins
    issue(weird, st);
    issue(use3, st);
    check_eq("prio_stall_cycles", st, 0);
    repeat (3) issue(nop, st);

    // Random traffic with a small register set to provoke hazards
    for (int n = 0; n < 80; n++) begin
      r.rw     = 1'($urandom_range(0, 1));
      r.alusrc = 1'($urandom_range(0, 1));
      r.memw   = 1'($urandom_range(0, 3) == 0);
      r.rsrc   = 1'($urandom_range(0, 2) == 0);
      r.br     = 1'($urandom_range(0, 3) == 0);
      r.aluop  = 2'($urandom_range(0, 3));
      r.rs1    = 5'($urandom_range(0, 3));
      r.rs2    = 5'($urandom_range(0, 3));
      r.rd     = 5'($urandom_range(0, 3));
      r.zero   = 1'($urandom_range(0, 1));
      issue(r, st);
    end
    repeat (3) issue(nop, st);

    // Asynchronous reset with a store in MEM
    issue(sw, st);
    issue(nop, st);
    @(posedge clk); #2;
    check_eq("sw_in_mem", bus.mem_MemWrite, 1'b1);
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_async");
    drive(r9);
    @(posedge clk); #1;
    check_all_zero("reset_hold");
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    check_all_zero("reset_release");
    sb_reset();
    issue(r9, st);
    repeat (4) issue(nop, st);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_pipeline.md
CONTROL_PIPELINE -- requirements
Module: control_pipeline

Interface
REQ-001 SHALL have port clk, input, 1: single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have ports id_RegWrite, id_ALUSrc, id_MemWrite, id_ResultSrc, id_Branch, each input, 1: decode-stage control bits from the main decoder.
REQ-004 SHALL have port id_ALUOp, input, 2: decode-stage ALU operation class.
REQ-005 SHALL have ports id_rs1, id_rs2, id_rd, each input, 5: decode-stage register indices.
REQ-006 SHALL have port ex_Zero, input, 1: ALU zero flag for the instruction in EX.
REQ-007 SHALL have ports ex_ALUSrc (1), ex_ALUOp (2), ex_rd (5), all outputs: EX-stage control.
REQ-008 SHALL have ports mem_MemWrite (1), mem_RegWrite (1), mem_rd (5), all outputs: MEM-stage control.
REQ-009 SHALL have ports wb_RegWrite (1), wb_ResultSrc (1), wb_rd (5), all outputs: WB-stage control.
REQ-010 SHALL have ports stall_F, stall_D, flush_D, PCSrc_E, each output, 1: hazard and redirect controls.

Function
REQ-011 SHALL hold three register stages: ID/EX, EX/MEM and MEM/WB, each carrying RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp and rd.
REQ-012 SHALL capture id_* into ID/EX on each clock edge, so ID values appear on ex_* after 1 cycle, on mem_* after 2 cycles and on wb_* after 3 cycles.
REQ-013 SHALL capture RegWrite into ID/EX as id_RegWrite AND (id_rd != 0); writes to x0 never propagate.
REQ-014 SHALL define a bubble as every control bit 0, ALUOp 2'b00 and rd 0.
REQ-015 SHALL assert PCSrc_E combinationally when ID/EX Branch = 1 and ex_Zero = 1.
REQ-016 SHALL assert flush_D = PCSrc_E, and SHALL load a bubble into ID/EX on the edge where PCSrc_E = 1.
REQ-017 SHALL define load-use as: ID/EX ResultSrc = 1, ID/EX RegWrite = 1, ex_rd != 0, and ex_rd equal to id_rs1 or id_rs2.
REQ-018 SHALL assert stall_F = stall_D = 1 combinationally during load-use when PCSrc_E = 0, and SHALL load a bubble into ID/EX on that edge.
REQ-019 SHALL give PCSrc_E priority on simultaneous branch-taken and load-use: stall_F = stall_D = 0, flush_D = 1, and a single bubble into ID/EX.
REQ-020 SHALL advance EX/MEM and MEM/WB unconditionally every cycle, since no downstream stall exists.
REQ-021 SHALL resolve a load-use stall in exactly 1 cycle: the following cycle the load is in MEM, so stall deasserts unless a new load-use occurs.
REQ-022 SHALL derive stall_F, stall_D, flush_D and PCSrc_E only from ID/EX state, ex_Zero and id_rs1/id_rs2; they SHALL have no combinational path from other id_* control bits.

Reset
REQ-023 SHALL clear all three stages to bubbles immediately on rst_n low, independent of clk.
REQ-024 SHALL therefore drive all ex_*, mem_* and wb_* outputs to 0 during reset, along with PCSrc_E, flush_D, stall_F and stall_D.
REQ-025 SHALL, on rst_n rising, capture id_* at the first clock edge; reset asserted mid-operation SHALL discard all in-flight instructions with no partial writes.

Verification
REQ-026 SHALL pass this check: apply R-type (RegWrite=1, ALUOp=10, rd=5) for one cycle, then bubbles -> ex_ALUOp=10 and ex_rd=5 at cycle 1; mem_RegWrite=1 at cycle 2; wb_RegWrite=1, wb_rd=5 and wb_ResultSrc=0 at cycle 3; all outputs 0 at cycle 4.
REQ-027 SHALL pass this check: lw (rd=7) followed by an instruction with rs1=7 -> stall_F = stall_D = 1 for exactly 1 cycle; ex_* is a bubble the next cycle; the dependent instruction reaches EX one cycle later.
REQ-028 SHALL pass this check: lw rd=0 followed by an instruction with rs1=0 -> no stall, and RegWrite is 0 in every stage.
REQ-029 SHALL pass this check: beq in EX with ex_Zero=1 -> PCSrc_E = flush_D = 1 in that cycle; ex_* is a bubble next cycle. With ex_Zero=0 -> PCSrc_E=0 and no bubble.
REQ-030 SHALL pass this check: force ID/EX to Branch=1, ResultSrc=1, RegWrite=1, rd=3 with ex_Zero=1 and id_rs1=3 -> PCSrc_E=1, flush_D=1, stall_F=0, stall_D=0.
REQ-031 SHALL pass this check: assert rst_n low mid-clock with sw in MEM -> mem_MemWrite falls to 0 before the next edge; all outputs stay 0 until the first edge after release.
